mem_txn_unit: RTL and testbench
===============================

Name: mem_txn_unit

Overview:
Memory-side transaction engine that executes the burst reads and writes the control unit triggers. It sits downstream of CU. It consumes the initReadTx/initWriteTx pulses and returns the readTxnDone/writeTxnDone levels and the MemMU status word. It drives a subset of an AXI4 master and streams burst data to and from the ExMU cache.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 64, AXI data width and cache word width
BURST_LEN, 16, beats per transaction (1..256); arlen/awlen = BURST_LEN-1
REGION_BYTES, 32'h0010_0000, size of each circular buffer region; power of two, multiple of burst bytes
TIMEOUT_CYCLES, 1024, watchdog limit; used only with MEMMU_TIMEOUT_EN

Ports:
i_SYSTEM_clk  in  1  system clock
i_SYSTEM_rst  in  1  synchronous reset, active-high
i_CU_INT_initReadTx  in  1  pulse: start one read burst (memory -> cache)
i_CU_INT_initWriteTx  in  1  pulse: start one write burst (cache -> memory)
i_CU_MonU_processingDone  in  1  frame finished; rewind both address pointers
i_MemMU_readBase  in  ADDR_W  read region base address
i_MemMU_writeBase  in  ADDR_W  write region base address
o_INT_readTxnDone  out  1  high while the read FSM is idle
o_INT_writeTxnDone  out  1  high while the write FSM is idle
o_MemMU_status  out  32  status word to CU (error = 32'hFFFFFFFF)
o_MemMU_ExMU_rdValid  out  1  read beat valid toward the cache
o_MemMU_ExMU_rdData  out  DATA_W  read beat data
o_MemMU_ExMU_rdIndex  out  8  beat index within the burst
o_MemMU_ExMU_wrIndex  out  8  index of the cache word requested
i_ExMU_MemMU_wrData  in  DATA_W  cache word at wrIndex, combinational
m_axi_araddr/arlen/arvalid  out  ADDR_W/8/1  AR channel
m_axi_arready  in  1
m_axi_rdata/rresp/rlast/rvalid  in  DATA_W/2/1/1  R channel
m_axi_rready  out  1
m_axi_awaddr/awlen/awvalid  out  ADDR_W/8/1  AW channel
m_axi_awready  in  1
m_axi_wdata/wlast/wvalid  out  DATA_W/1/1  W channel
m_axi_wready  in  1
m_axi_bresp/bvalid  in  2/1  B channel
m_axi_bready  out  1

Behaviour:
- Reset values:
  - all valid/ready/last outputs 0; done outputs 1; status 0
  - pointers = 0; indices = 0; rdData = 0
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: when initReadTx=1, register araddr = readBase + rdPtr and go to R_ADDR. readTxnDone falls on the next cycle, so it is low in the cycle after the pulse.
  - R_ADDR: arvalid=1 until arready; araddr and arlen stay stable while arvalid=1.
  - R_DATA: rready=1.
    - Each rvalid beat gives rdValid=1 with rdData=rdata and rdIndex = beat count, registered 1 cycle after the beat.
    - The beat with rlast: return to R_IDLE and set rdPtr += BURST_LEN*DATA_W/8, modulo REGION_BYTES.
    - readTxnDone rises the cycle after the last rdValid.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - Captures awaddr = writeBase + wrPtr.
  - W_ADDR and W_DATA run sequentially: the W channel starts only after the AW handshake.
  - W_DATA: wdata = i_ExMU_MemMU_wrData for wrIndex. wrIndex advances on each wvalid&&wready; wlast=1 when wrIndex = BURST_LEN-1.
  - W_RESP: bready=1. On bvalid, advance wrPtr as for reads and return to W_IDLE.
- The two FSMs are independent. Simultaneous initReadTx and initWriteTx start both.
- An init pulse while its FSM is busy is ignored and sets the sticky status bit overrun.
- i_CU_MonU_processingDone=1 in any cycle zeroes both pointers. It takes effect for the next transaction and does not disturb a transaction in flight.
- Response errors:
  - rresp != 0 or bresp != 0 sets the sticky error flag; the burst still completes normally.
  - While error=1, o_MemMU_status = 32'hFFFFFFFF. Only reset clears it.
- Status (non-error): [0] read busy, [1] write busy, [2] overrun, [3] timeout (feature), [15:8] completed-read count mod 256, [23:16] completed-write count mod 256, others 0.
- Pointer wrap: the pointer that would reach REGION_BYTES becomes 0, with no carry into the base.
- A reset in mid-burst aborts immediately: all outputs return to reset values and no AXI cleanup is performed.

Optional Feature:
MEMMU_TIMEOUT_EN
- Defined:
  - One watchdog counter per FSM, cleared on any handshake of its channel and whenever its FSM is idle.
  - When a counter reaches TIMEOUT_CYCLES, set status[3] and the sticky error flag, and force that FSM to idle, releasing its valids.
- Undefined: no counters; status[3] is always 0; FSMs wait indefinitely.

Test Plan:
- Read, readBase=0x1000, BURST_LEN=16, DATA_W=64, arready immediate, 16 R beats (data 0..15, rlast on beat 16) -> araddr=0x1000, arlen=15; rdIndex 0..15 with matching data; readTxnDone low in the cycle after the pulse, high 1 cycle after rdIndex 15; next araddr=0x1080.
- Write with wready toggling every other cycle, bresp=0 -> awaddr=writeBase, 16 W beats with wlast on the 16th, wrIndex 0..15; writeTxnDone rises the cycle after bvalid; status[23:16]=1.
- Same-cycle init of read and write -> both bursts run concurrently; both done levels low, both later high; counters both 1.
- initReadTx during R_DATA -> no second AR; status[2]=1; transfer unaffected.
- rresp=2'b10 on beat 5 -> burst completes; o_MemMU_status=32'hFFFFFFFF until reset; reset -> status 0, done=1.
- REGION_BYTES=0x100 with 2 read bursts -> araddr base+0x80, then base+0x00 (wrap); processingDone pulse -> next araddr = base.

Source files
------------

// File: rtl/mem_txn_unit.sv
// Burst read/write AXI4 master feeding the ExMU cache from two circular regions; reads return beats 1 cycle after R.
// Channels stall on AXI ready/valid; the optional watchdog (MEMMU_TIMEOUT_EN) forces a stuck FSM back to idle.
module mem_txn_unit #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 64,
    parameter int          BURST_LEN      = 16,
    parameter logic [31:0] REGION_BYTES   = 32'h0010_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic              i_SYSTEM_clk,
    input  logic              i_SYSTEM_rst,
    input  logic              i_CU_INT_initReadTx,
    input  logic              i_CU_INT_initWriteTx,
    input  logic              i_CU_MonU_processingDone,
    input  logic [ADDR_W-1:0] i_MemMU_readBase,
    input  logic [ADDR_W-1:0] i_MemMU_writeBase,
    output logic              o_INT_readTxnDone,
    output logic              o_INT_writeTxnDone,
    output logic [31:0]       o_MemMU_status,
    output logic              o_MemMU_ExMU_rdValid,
    output logic [DATA_W-1:0] o_MemMU_ExMU_rdData,
    output logic [7:0]        o_MemMU_ExMU_rdIndex,
    output logic [7:0]        o_MemMU_ExMU_wrIndex,
    input  logic [DATA_W-1:0] i_ExMU_MemMU_wrData,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready
);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0] REGION_MASK = ADDR_W'(REGION_BYTES - 32'd1);
    localparam logic [7:0]        LAST_IDX    = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [7:0]        rd_beat, rd_cnt, wr_cnt;
    logic              err_flag, overrun_flag, timeout_flag;
    logic              rd_to, wr_to;

    assign m_axi_arlen = LAST_IDX;
    assign m_axi_awlen = LAST_IDX;
    assign m_axi_wdata = i_ExMU_MemMU_wrData;
    assign m_axi_wlast = m_axi_wvalid && (o_MemMU_ExMU_wrIndex == LAST_IDX);

    assign o_MemMU_status = err_flag ? 32'hFFFF_FFFF :
        {8'h00, wr_cnt, rd_cnt, 4'h0, timeout_flag, overrun_flag, ~o_INT_writeTxnDone, ~o_INT_readTxnDone};

`ifdef MEMMU_TIMEOUT_EN
    logic [31:0] rd_wdog, wr_wdog;

    // Counters restart on any handshake of their own channels and hold at zero while idle.
    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            rd_wdog <= '0;
            wr_wdog <= '0;
        end else begin
            if (r_state == R_IDLE || rd_to || (m_axi_arvalid && m_axi_arready) || (m_axi_rready && m_axi_rvalid))
                rd_wdog <= '0;
            else
                rd_wdog <= rd_wdog + 32'd1;
            if (w_state == W_IDLE || wr_to || (m_axi_awvalid && m_axi_awready) ||
                (m_axi_wvalid && m_axi_wready) || (m_axi_bready && m_axi_bvalid))
                wr_wdog <= '0;
            else
                wr_wdog <= wr_wdog + 32'd1;
        end
    end

    assign rd_to = (rd_wdog == 32'(TIMEOUT_CYCLES));
    assign wr_to = (wr_wdog == 32'(TIMEOUT_CYCLES));
`else
    assign rd_to = 1'b0;
    assign wr_to = 1'b0;
`endif

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            err_flag     <= 1'b0;
            overrun_flag <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if ((i_CU_INT_initReadTx && r_state != R_IDLE) || (i_CU_INT_initWriteTx && w_state != W_IDLE))
                overrun_flag <= 1'b1;
            if ((r_state == R_DATA && m_axi_rvalid && m_axi_rresp != 2'b00) ||
                (w_state == W_RESP && m_axi_bvalid && m_axi_bresp != 2'b00) || rd_to || wr_to)
                err_flag <= 1'b1;
            if (rd_to || wr_to)
                timeout_flag <= 1'b1;
        end
    end

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            r_state              <= R_IDLE;
            m_axi_araddr         <= '0;
            m_axi_arvalid        <= 1'b0;
            m_axi_rready         <= 1'b0;
            o_MemMU_ExMU_rdValid <= 1'b0;
            o_MemMU_ExMU_rdData  <= '0;
            o_MemMU_ExMU_rdIndex <= '0;
            o_INT_readTxnDone    <= 1'b1;
            rd_beat              <= '0;
            rd_cnt               <= '0;
            rd_ptr               <= '0;
        end else begin
            o_MemMU_ExMU_rdValid <= 1'b0;
            // Done trails the FSM by a cycle so it rises only after the last beat reached the cache.
            o_INT_readTxnDone    <= (r_state == R_IDLE) && !i_CU_INT_initReadTx;
            if (rd_to) begin
                r_state       <= R_IDLE;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
            end else begin
                case (r_state)
                    R_IDLE: if (i_CU_INT_initReadTx) begin
                        m_axi_araddr  <= i_MemMU_readBase + rd_ptr;
                        m_axi_arvalid <= 1'b1;
                        r_state       <= R_ADDR;
                    end
                    R_ADDR: if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        rd_beat       <= '0;
                        r_state       <= R_DATA;
                    end
                    R_DATA: if (m_axi_rvalid) begin
                        o_MemMU_ExMU_rdValid <= 1'b1;
                        o_MemMU_ExMU_rdData  <= m_axi_rdata;
                        o_MemMU_ExMU_rdIndex <= rd_beat;
                        rd_beat              <= rd_beat + 8'd1;
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
                            rd_cnt       <= rd_cnt + 8'd1;
                            rd_ptr       <= (rd_ptr + BURST_BYTES) & REGION_MASK;
                            r_state      <= R_IDLE;
                        end
                    end
                    default: r_state <= R_IDLE;
                endcase
            end
            if (i_CU_MonU_processingDone)
                rd_ptr <= '0;
        end
    end

    always_ff @(posedge i_SYSTEM_clk) begin
        if (i_SYSTEM_rst) begin
            w_state              <= W_IDLE;
            m_axi_awaddr         <= '0;
            m_axi_awvalid        <= 1'b0;
            m_axi_wvalid         <= 1'b0;
            m_axi_bready         <= 1'b0;
            o_MemMU_ExMU_wrIndex <= '0;
            o_INT_writeTxnDone   <= 1'b1;
            wr_cnt               <= '0;
            wr_ptr               <= '0;
        end else begin
            if (wr_to) begin
                w_state            <= W_IDLE;
                m_axi_awvalid      <= 1'b0;
                m_axi_wvalid       <= 1'b0;
                m_axi_bready       <= 1'b0;
                o_INT_writeTxnDone <= 1'b1;
            end else begin
                case (w_state)
                    W_IDLE: if (i_CU_INT_initWriteTx) begin
                        m_axi_awaddr       <= i_MemMU_writeBase + wr_ptr;
                        m_axi_awvalid      <= 1'b1;
                        o_INT_writeTxnDone <= 1'b0;
                        w_state            <= W_ADDR;
                    end
                    W_ADDR: if (m_axi_awready) begin
                        m_axi_awvalid        <= 1'b0;
                        m_axi_wvalid         <= 1'b1;
                        o_MemMU_ExMU_wrIndex <= '0;
                        w_state              <= W_DATA;
                    end
                    W_DATA: if (m_axi_wready) begin
                        if (o_MemMU_ExMU_wrIndex == LAST_IDX) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_bready <= 1'b1;
                            w_state      <= W_RESP;
                        end else begin
                            o_MemMU_ExMU_wrIndex <= o_MemMU_ExMU_wrIndex + 8'd1;
                        end
                    end
                    W_RESP: if (m_axi_bvalid) begin
                        m_axi_bready       <= 1'b0;
                        o_INT_writeTxnDone <= 1'b1;
                        wr_cnt             <= wr_cnt + 8'd1;
                        wr_ptr             <= (wr_ptr + BURST_BYTES) & REGION_MASK;
                        w_state            <= W_IDLE;
                    end
                    default: w_state <= W_IDLE;
                endcase
            end
            if (i_CU_MonU_processingDone)
                wr_ptr <= '0;
        end
    end
endmodule

// File: tb/tb_mem_txn_unit.sv
// Scoreboard bench for mem_txn_unit: directed bursts against a small AXI slave model and a cache word model.
// REGION_BYTES is 0x100 so two 128-byte bursts fill a region and the third wraps.
module tb_mem_txn_unit;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BL     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_rd = 1'b0, init_wr = 1'b0, proc_done = 1'b0;
    logic [ADDR_W-1:0] read_base = 32'h1000, write_base = 32'h2000;
    logic              rd_done, wr_done, rd_valid;
    logic [31:0]       status;
    logic [DATA_W-1:0] rd_data, wr_data;
    logic [7:0]        rd_index, wr_index;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [7:0]        arlen, awlen;
    logic              arvalid, arready = 1'b1, rready;
    logic [DATA_W-1:0] rdata = '0, wdata;
    logic [1:0]        rresp = 2'b00, bresp = 2'b00;
    logic              rlast = 1'b0, rvalid = 1'b0;
    logic              awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b0;
    logic              bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    assign wr_data = 64'hCAFE_0000_0000_0000 | 64'(wr_index);

    mem_txn_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL),
                   .REGION_BYTES(32'h0000_0100), .TIMEOUT_CYCLES(1024)) dut (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst),
        .i_CU_INT_initReadTx(init_rd), .i_CU_INT_initWriteTx(init_wr),
        .i_CU_MonU_processingDone(proc_done),
        .i_MemMU_readBase(read_base), .i_MemMU_writeBase(write_base),
        .o_INT_readTxnDone(rd_done), .o_INT_writeTxnDone(wr_done), .o_MemMU_status(status),
        .o_MemMU_ExMU_rdValid(rd_valid), .o_MemMU_ExMU_rdData(rd_data),
        .o_MemMU_ExMU_rdIndex(rd_index), .o_MemMU_ExMU_wrIndex(wr_index),
        .i_ExMU_MemMU_wrData(wr_data),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [71:0] rd_q[$];
    logic [7:0]  w_q[$];
    int          rd_seed  = 0;
    int          err_beat = -1;

    // Scoreboard monitor: every DUT-presented transfer pops its expectation.
    initial begin
        bit          rd_pend;
        logic [71:0] e;
        logic [7:0]  wi;
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_pend) begin
                    check("rd_done_rise_after_last", 64'(rd_done), 64'd1);
                    rd_pend = 1'b0;
                end
                if (arvalid && arready) begin
                    check("ar_expected", 64'(ar_q.size() != 0), 64'd1);
                    if (ar_q.size() != 0) begin
                        check("araddr", 64'(araddr), 64'(ar_q.pop_front()));
                        check("arlen", 64'(arlen), 64'd15);
                    end
                end
                if (rd_valid) begin
                    check("rd_beat_expected", 64'(rd_q.size() != 0), 64'd1);
                    if (rd_q.size() != 0) begin
                        e = rd_q.pop_front();
                        check("rd_index", 64'(rd_index), 64'(e[71:64]));
                        check("rd_data", rd_data, e[63:0]);
                        if (e[71:64] == 8'd15) begin
                            check("rd_done_low_at_last", 64'(rd_done), 64'd0);
                            rd_pend = 1'b1;
                        end
                    end
                end
                if (awvalid && awready) begin
                    check("aw_expected", 64'(aw_q.size() != 0), 64'd1);
                    if (aw_q.size() != 0) begin
                        check("awaddr", 64'(awaddr), 64'(aw_q.pop_front()));
                        check("awlen", 64'(awlen), 64'd15);
                    end
                end
                if (wvalid && wready) begin
                    check("w_beat_expected", 64'(w_q.size() != 0), 64'd1);
                    if (w_q.size() != 0) begin
                        wi = w_q.pop_front();
                        check("wr_index", 64'(wr_index), 64'(wi));
                        check("wdata", wdata, 64'hCAFE_0000_0000_0000 | 64'(wi));
                        check("wlast", 64'(wlast), 64'(wi == 8'd15));
                    end
                end
            end
        end
    end

    // AXI read slave: 16 back-to-back beats right after each AR handshake.
    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (!rst && arvalid && arready) begin
                s = rd_seed;
                @(posedge clk); #1;
                for (int i = 0; i < BL; i++) begin
                    rvalid = 1'b1;
                    rdata  = {32'(s), 32'(i)};
                    rlast  = (i == BL - 1);
                    rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                    @(posedge clk); #1;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        wready = ~wready;
    end

    // AXI write response: bvalid right after the last W beat, done must rise the cycle after.
    initial forever begin
        @(negedge clk);
        if (!rst && wvalid && wready && wlast) begin
            @(posedge clk); #1;
            bvalid = 1'b1;
            @(negedge clk);
            check("wr_done_low_during_b", 64'(wr_done), 64'd0);
            @(posedge clk); #1;
            bvalid = 1'b0;
            @(negedge clk);
            check("wr_done_rise_after_b", 64'(wr_done), 64'd1);
        end
    end

    task automatic expect_read(input logic [31:0] addr, input int seed);
        ar_q.push_back(addr);
        rd_seed = seed;
        for (int i = 0; i < BL; i++)
            rd_q.push_back({8'(i), 32'(seed), 32'(i)});
    endtask

    task automatic expect_write(input logic [31:0] addr);
        aw_q.push_back(addr);
        for (int i = 0; i < BL; i++)
            w_q.push_back(8'(i));
    endtask

    task automatic pulse(input bit r, input bit w, input bit pd);
        @(posedge clk); #1;
        init_rd = r; init_wr = w; proc_done = pd;
        @(posedge clk); #1;
        init_rd = 1'b0; init_wr = 1'b0; proc_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(rd_done && wr_done && ar_q.size() == 0 && aw_q.size() == 0 &&
                 rd_q.size() == 0 && w_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 64'(n < 300), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_done", 64'(rd_done), 64'd1);
        check("rst_wr_done", 64'(wr_done), 64'd1);
        check("rst_status", 64'(status), 64'd0);
        check("rst_valids", 64'({arvalid, rready, awvalid, wvalid, wlast, bready, rd_valid}), 64'd0);
        check("rst_indices", 64'({rd_index, wr_index}), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        expect_read(32'h1000, 1);
        pulse(1, 0, 0);
        @(negedge clk);
        check("rd1_done_low_after_pulse", 64'(rd_done), 64'd0);
        wait_idle("rd1");
        check("status_rd1", 64'(status), 64'h0000_0100);

        expect_read(32'h1080, 2);
        pulse(1, 0, 0);
        wait_idle("rd2");
        check("status_rd2", 64'(status), 64'h0000_0200);

        expect_write(32'h2000);
        pulse(0, 1, 0);
        @(negedge clk);
        check("wr1_done_low_after_pulse", 64'(wr_done), 64'd0);
        wait_idle("wr1");
        check("status_wr1", 64'(status), 64'h0001_0200);

        expect_read(32'h1000, 3);
        expect_write(32'h2080);
        pulse(1, 1, 0);
        @(negedge clk);
        check("both_busy", 64'(status[1:0]), 64'd3);
        wait_idle("both");
        check("status_both", 64'(status), 64'h0002_0300);

        expect_read(32'h1080, 4);
        pulse(1, 0, 0);
        repeat (4) @(posedge clk);
        pulse(1, 0, 0);
        wait_idle("overrun");
        check("status_overrun", 64'(status), 64'h0002_0404);

        expect_read(32'h1000, 5);
        pulse(1, 0, 0);
        wait_idle("rd_pre_rewind");
        pulse(0, 0, 1);
        expect_read(32'h1000, 6);
        pulse(1, 0, 0);
        wait_idle("rd_rewind");
        check("status_rewind", 64'(status), 64'h0002_0604);

        err_beat = 5;
        expect_read(32'h1080, 7);
        pulse(1, 0, 0);
        wait_idle("rd_err");
        err_beat = -1;
        check("status_error", 64'(status), 64'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        check("status_error_sticky", 64'(status), 64'hFFFF_FFFF);

        do_reset();
        expect_read(32'h1000, 8);
        pulse(1, 0, 0);
        wait_idle("rd_after_reset");
        check("status_after_reset", 64'(status), 64'h0000_0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
